alu_wb_arbiter: RTL and testbench

Shares one physical-register-file write port among NUM_REQ ALU pipelines. Each pipeline's writeback (valid, data, PR) is captured in a small per-requester FIFO. A round-robin arbiter selects one non-empty FIFO per cycle into a registered output stage. The output stage drives the PRF write port and holds until the port accepts. Back-pressure returns to each ALU pipeline through its ready_out.

---
 rtl/core_types_pkg.sv | 12 +
 rtl/alu_wb_arbiter_if.sv | 26 ++
 rtl/alu_wb_arbiter_sva.sv | 30 +++
 rtl/alu_wb_req_fifo.sv | 54 +++++
 rtl/alu_wb_arbiter.sv | 95 +++++++++
 tb/tb_alu_wb_arbiter.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/core_types_pkg.sv
// Core-wide types shared by the execution back end.
// wb_req_t is one ALU writeback: result data plus destination physical register.
package core_types_pkg;

    localparam int LOG_PR_COUNT = 6;

    typedef struct packed {
        logic [31:0]             data;
        logic [LOG_PR_COUNT-1:0] PR;
    } wb_req_t;

endpackage

// File: rtl/alu_wb_arbiter_if.sv
// Bundle of ALU writeback requests and the shared PRF write port.
interface alu_wb_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import core_types_pkg::*;

    logic [NUM_REQ-1:0]              WB_valid_in;
    logic [NUM_REQ*32-1:0]           WB_data_in;
    logic [NUM_REQ*LOG_PR_COUNT-1:0] WB_PR_in;
    logic [NUM_REQ-1:0]              ready_out;
    logic                            WB_valid_out;
    logic [31:0]                     WB_data_out;
    logic [LOG_PR_COUNT-1:0]         WB_PR_out;
    logic                            WB_ready_in;

    modport master (
        output WB_valid_in, WB_data_in, WB_PR_in, WB_ready_in,
        input  ready_out, WB_valid_out, WB_data_out, WB_PR_out
    );

    modport slave (
        input  WB_valid_in, WB_data_in, WB_PR_in, WB_ready_in,
        output ready_out, WB_valid_out, WB_data_out, WB_PR_out
    );

endinterface

// File: rtl/alu_wb_arbiter_sva.sv
// Protocol checks for the writeback arbiter: reset values, hold stability
// and back-pressure whenever a requester FIFO is full.
module alu_wb_arbiter_sva
    import core_types_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic                    CLK,
    input logic                    nRST,
    input logic [NUM_REQ-1:0]      ready_out,
    input logic [NUM_REQ-1:0]      fifo_full,
    input logic                    WB_valid_out,
    input logic                    WB_ready_in,
    input logic [31:0]             WB_data_out,
    input logic [LOG_PR_COUNT-1:0] WB_PR_out
);

    a_reset_values: assert property (@(posedge CLK)
        !nRST |-> (!WB_valid_out && WB_data_out == '0 && WB_PR_out == '0 && ready_out == '1));

    a_hold_stable: assert property (@(posedge CLK) disable iff (!nRST)
        (WB_valid_out && !WB_ready_in) |=>
        (WB_valid_out && $stable(WB_data_out) && $stable(WB_PR_out)));

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_full_chk
        a_full_not_ready: assert property (@(posedge CLK) disable iff (!nRST)
            fifo_full[gi] |-> !ready_out[gi]);
    end

endmodule

// File: rtl/alu_wb_req_fifo.sv
// Per-pipeline writeback FIFO: circular buffer with a combinational head.
// Pushes while full and pops while empty are dropped internally.
module alu_wb_req_fifo
    import core_types_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic    CLK,
    input  logic    nRST,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t dout,
    output logic    full,
    output logic    empty
);
    localparam int LOG_DEPTH = $clog2(BUF_DEPTH);
    localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH+1)'(BUF_DEPTH);

    wb_req_t              mem_reg [BUF_DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_reg;
    logic [LOG_DEPTH-1:0] rd_ptr_reg;
    logic [LOG_DEPTH:0]   count_reg;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + LOG_DEPTH'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + LOG_DEPTH'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (LOG_DEPTH+1)'(1);
                2'b01:   count_reg <= count_reg - (LOG_DEPTH+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge CLK) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/alu_wb_arbiter.sv
// Shares one PRF write port among NUM_REQ ALU pipelines: per-pipeline FIFOs,
// a round-robin grant, and a registered output stage that holds until accepted.
module alu_wb_arbiter
    import core_types_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUF_DEPTH = 2
) (
    input logic              CLK,
    input logic              nRST,
    alu_wb_arbiter_if.slave  wb
);
    localparam int LOG_REQ = $clog2(NUM_REQ);

    wb_req_t              fifo_din  [NUM_REQ];
    wb_req_t              fifo_head [NUM_REQ];
    logic [NUM_REQ-1:0]   fifo_full;
    logic [NUM_REQ-1:0]   fifo_empty;
    logic [NUM_REQ-1:0]   fifo_pop;

    logic [LOG_REQ-1:0]   rr_ptr_reg;
    logic [LOG_REQ-1:0]   grant_idx;
    logic                 grant_valid;
    logic                 stage_free;
    logic                 out_valid_reg;
    wb_req_t              out_req_reg;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign fifo_din[gi] = {wb.WB_data_in[32*gi +: 32],
                               wb.WB_PR_in[LOG_PR_COUNT*gi +: LOG_PR_COUNT]};
        assign fifo_pop[gi] = stage_free && grant_valid && (grant_idx == LOG_REQ'(gi));

        alu_wb_req_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
            .CLK   (CLK),
            .nRST  (nRST),
            .push  (wb.WB_valid_in[gi]),
            .pop   (fifo_pop[gi]),
            .din   (fifo_din[gi]),
            .dout  (fifo_head[gi]),
            .full  (fifo_full[gi]),
            .empty (fifo_empty[gi])
        );
    end

    // ready_out comes from registered counts only, so a pop never frees a slot early.
    assign wb.ready_out    = ~fifo_full;
    assign stage_free      = !out_valid_reg || wb.WB_ready_in;

    // First non-empty FIFO at or after rr_ptr; index arithmetic wraps at NUM_REQ.
    always_comb begin
        logic [LOG_REQ-1:0] cand_idx;
        cand_idx    = rr_ptr_reg;
        grant_valid = 1'b0;
        grant_idx   = rr_ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = rr_ptr_reg + LOG_REQ'(k);
            if (!grant_valid && !fifo_empty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_reg <= 1'b0;
            out_req_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else if (stage_free) begin
            if (grant_valid) begin
                out_valid_reg <= 1'b1;
                out_req_reg   <= fifo_head[grant_idx];
                rr_ptr_reg    <= grant_idx + LOG_REQ'(1);
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign wb.WB_valid_out = out_valid_reg;
    assign wb.WB_data_out  = out_req_reg.data;
    assign wb.WB_PR_out    = out_req_reg.PR;

    alu_wb_arbiter_sva #(.NUM_REQ(NUM_REQ)) u_sva (
        .CLK          (CLK),
        .nRST         (nRST),
        .ready_out    (wb.ready_out),
        .fifo_full    (fifo_full),
        .WB_valid_out (wb.WB_valid_out),
        .WB_ready_in  (wb.WB_ready_in),
        .WB_data_out  (wb.WB_data_out),
        .WB_PR_out    (wb.WB_PR_out)
    );

endmodule

// File: tb/tb_alu_wb_arbiter.sv
// Bench for alu_wb_arbiter: directed scenarios plus random traffic, all compared
// every cycle against a queue-based reference of the writeback port.
module tb_alu_wb_arbiter;
    import core_types_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int BUF_DEPTH = 2;

    logic                            CLK    = 1'b0;
    logic                            nRST   = 1'b1;
    logic [NUM_REQ-1:0]              v_in   = '0;
    logic [NUM_REQ*32-1:0]           d_bus  = '0;
    logic [NUM_REQ*LOG_PR_COUNT-1:0] p_bus  = '0;
    logic                            rdy_in = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: one queue per requester plus the output slot and next-priority index.
    wb_req_t                 mq [NUM_REQ][$];
    logic                    m_valid;
    logic [31:0]             m_data;
    logic [LOG_PR_COUNT-1:0] m_pr;
    int                      m_rr;
    logic [NUM_REQ-1:0]      m_acc;

    alu_wb_arbiter_if #(.NUM_REQ(NUM_REQ)) wb_if ();

    assign wb_if.WB_valid_in = v_in;
    assign wb_if.WB_data_in  = d_bus;
    assign wb_if.WB_PR_in    = p_bus;
    assign wb_if.WB_ready_in = rdy_in;

    alu_wb_arbiter #(.NUM_REQ(NUM_REQ), .BUF_DEPTH(BUF_DEPTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .wb   (wb_if)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_pr    = '0;
        m_rr    = 0;
        m_acc   = '0;
        for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
    endtask

    task automatic model_step();
        bit      free;
        int      g;
        int      j;
        wb_req_t e;
        for (int i = 0; i < NUM_REQ; i++)
            m_acc[i] = v_in[i] && (mq[i].size() < BUF_DEPTH);
        free = !m_valid || rdy_in;
        if (free) begin
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (m_rr + k) % NUM_REQ;
                if (g < 0 && mq[j].size() > 0) g = j;
            end
            if (g >= 0) begin
                e       = mq[g].pop_front();
                m_valid = 1'b1;
                m_data  = e.data;
                m_pr    = e.PR;
                m_rr    = (g + 1) % NUM_REQ;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_acc[i]) begin
                e.data = d_bus[32*i +: 32];
                e.PR   = p_bus[LOG_PR_COUNT*i +: LOG_PR_COUNT];
                mq[i].push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NUM_REQ; i++)
            check_eq($sformatf("ready_out[%0d]", i), 64'(wb_if.ready_out[i]),
                     64'(mq[i].size() != BUF_DEPTH));
        check_eq("WB_valid_out", 64'(wb_if.WB_valid_out), 64'(m_valid));
        check_eq("WB_data_out", 64'(wb_if.WB_data_out), 64'(m_data));
        check_eq("WB_PR_out", 64'(wb_if.WB_PR_out), 64'(m_pr));
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (nRST) model_step();
        else m_acc = '0;
        #1;
        check_outputs();
        $display("t=%0t valid_in=%b ready_in=%b ready_out=%b valid_out=%b data=0x%08h PR=%0d",
                 $time, v_in, rdy_in, wb_if.ready_out, wb_if.WB_valid_out,
                 wb_if.WB_data_out, wb_if.WB_PR_out);
        v_in = v_in & ~m_acc;
    endtask

    task automatic drive(input int i, input logic [31:0] d, input logic [LOG_PR_COUNT-1:0] p);
        v_in[i]                                  = 1'b1;
        d_bus[32*i +: 32]                        = d;
        p_bus[LOG_PR_COUNT*i +: LOG_PR_COUNT]    = p;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        v_in = '0;
        #1;
        model_reset();
        check_eq("rst_ready_out", 64'(wb_if.ready_out), 64'(4'hF));
        check_eq("rst_valid_out", 64'(wb_if.WB_valid_out), 64'd0);
        check_eq("rst_data_out", 64'(wb_if.WB_data_out), 64'd0);
        check_eq("rst_PR_out", 64'(wb_if.WB_PR_out), 64'd0);
        repeat (2) cycle();
        nRST = 1'b1;
    endtask

    initial begin
        int prev_id;
        int id;
        #2;
        do_reset();

        // Round-robin: two simultaneous bursts, each drains 0,1,2,3.
        rdy_in = 1'b1;
        repeat (2) begin
            for (int i = 0; i < NUM_REQ; i++) drive(i, 32'hA000_0000 | 32'(i), LOG_PR_COUNT'(i + 1));
            cycle();
            for (int k = 0; k < NUM_REQ; k++) begin
                cycle();
                check_eq("rr_order", 64'(wb_if.WB_data_out), 64'(32'hA000_0000 | 32'(k)));
            end
            cycle();
        end

        // Single requester: one-cycle latency, then idle.
        drive(2, 32'hDEAD_BEEF, LOG_PR_COUNT'(5));
        cycle();
        check_eq("single_k_valid", 64'(wb_if.WB_valid_out), 64'd0);
        cycle();
        check_eq("single_k1_valid", 64'(wb_if.WB_valid_out), 64'd1);
        check_eq("single_k1_data", 64'(wb_if.WB_data_out), 64'hDEAD_BEEF);
        check_eq("single_k1_PR", 64'(wb_if.WB_PR_out), 64'd5);
        cycle();
        check_eq("single_k2_valid", 64'(wb_if.WB_valid_out), 64'd0);

        // Back-pressure: requester 1 streams against a stalled port.
        rdy_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!v_in[1]) drive(1, 32'hB100_0000 + 32'(c), LOG_PR_COUNT'(c));
            cycle();
        end
        check_eq("bp_ready1", 64'(wb_if.ready_out[1]), 64'd0);
        check_eq("bp_hold_data", 64'(wb_if.WB_data_out), 64'hB100_0000);
        rdy_in = 1'b1;
        for (int c = 1; c < 4; c++) begin
            cycle();
            check_eq("bp_drain", 64'(wb_if.WB_data_out), 64'(32'hB100_0000 + 32'(c)));
        end
        repeat (3) cycle();

        // Full FIFO 0 with pops and pointer wrap over 20 pushes.
        for (int n = 0; n < 20; ) begin
            if (!v_in[0]) begin
                drive(0, 32'hC000_0000 + 32'(n), LOG_PR_COUNT'(n));
                n++;
            end
            rdy_in = ($urandom_range(0, 2) != 0);
            cycle();
        end
        rdy_in = 1'b1;
        repeat (6) cycle();

        // Fairness: requesters 0 and 3 stream continuously.
        prev_id = -1;
        for (int c = 0; c < 16; c++) begin
            if (!v_in[0]) drive(0, {4'd0, 28'(c)}, LOG_PR_COUNT'(c));
            if (!v_in[3]) drive(3, {4'd3, 28'(c)}, LOG_PR_COUNT'(c));
            cycle();
            if (wb_if.WB_valid_out) begin
                id = int'(wb_if.WB_data_out[31:28]);
                if (prev_id >= 0) check_eq("fair_alt", 64'(id), 64'((prev_id == 0) ? 3 : 0));
                prev_id = id;
            end
        end
        repeat (8) cycle();

        // Reset mid-stream with entries buffered.
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 32'hE000_0000 | 32'(i), LOG_PR_COUNT'(i));
        cycle();
        do_reset();
        rdy_in = 1'b1;
        repeat (4) cycle();
        check_eq("post_rst_valid", 64'(wb_if.WB_valid_out), 64'd0);

        // Random traffic with a reset in the middle.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!v_in[i] && ($urandom_range(0, 1) != 0))
                    drive(i, $urandom, LOG_PR_COUNT'($urandom));
            rdy_in = ($urandom_range(0, 3) != 0);
            if (c == 200) do_reset();
            cycle();
        end
        rdy_in = 1'b1;
        repeat (12) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
